// File: rtl/rf_seq_pkg.sv
// Shared constants for the register-file sequencer: state encoding, opcode/op values,
// write-back select codes and the decode path classification.
package rf_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_WAIT   = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] S_GET_A  = 3'd2;
    localparam logic [STATE_W-1:0] S_GET_B  = 3'd3;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd4;
    localparam logic [STATE_W-1:0] S_WR_IMM = 3'd5;
    localparam logic [STATE_W-1:0] S_WR_REG = 3'd6;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd7;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    // Which state follows DECODE for a legal instruction
    typedef enum logic [1:0] {
        PATH_NOP = 2'd0,
        PATH_IMM = 2'd1,
        PATH_A   = 2'd2,
        PATH_B   = 2'd3
    } path_e;

endpackage

// File: rtl/rf_seq_idec.sv
// Combinational instruction decoder: field extraction, immediate sign extension and
// path classification for the sequencer FSM.
module rf_seq_idec
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         rn,
    output logic [2:0]         rd,
    output logic [2:0]         rm,
    output logic [1:0]         sh,
    output logic [1:0]         op,
    output logic [DATA_W-1:0]  sximm8,
    output logic [DATA_W-1:0]  sximm5,
    output path_e              path,
    output logic               legal,
    output logic               is_cmp,
    output logic               is_mov_reg
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = DATA_W'($signed(ir[7:0]));
    assign sximm5 = DATA_W'($signed(ir[4:0]));

    always_comb begin
        path       = PATH_NOP;
        is_cmp     = 1'b0;
        is_mov_reg = 1'b0;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM) begin
                    path = PATH_IMM;
                end else if (op == OP_MOV_REG) begin
                    path       = PATH_B;
                    is_mov_reg = 1'b1;
                end
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: path = PATH_A;
                    OP_CMP: begin
                        path   = PATH_A;
                        is_cmp = 1'b1;
                    end
                    OP_MVN:  path = PATH_B;
                    default: path = PATH_NOP;
                endcase
            end
            default: path = PATH_NOP;
        endcase
    end

    assign legal = (path != PATH_NOP);

endmodule

// File: rtl/rf_seq_ctrl.sv
// Multi-cycle register-file/datapath sequencer. Define RF_SEQ_ILLEGAL_TRAP_EN to send
// illegal encodings to a HALT state held until reset; otherwise they retire as NOPs.
module rf_seq_ctrl
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic [2:0]         readnum,
    output logic [2:0]         writenum,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               vsel,
    output logic [1:0]         shift,
    output logic [1:0]         aluop,
    output logic [DATA_W-1:0]  sximm8,
    output logic [DATA_W-1:0]  sximm5
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [2:0] rn, rd, rm;
    logic [1:0] sh, op;
    path_e      path;
    logic       legal, is_cmp, is_mov_reg;

    rf_seq_idec #(.DATA_W(DATA_W)) u_idec (
        .ir         (ir_q),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .op         (op),
        .sximm8     (sximm8),
        .sximm5     (sximm5),
        .path       (path),
        .legal      (legal),
        .is_cmp     (is_cmp),
        .is_mov_reg (is_mov_reg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state; IR only loads on the accepting edge in WAIT
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end else begin
                    case (path)
                        PATH_IMM: state_d = S_WR_IMM;
                        PATH_A:   state_d = S_GET_A;
                        PATH_B:   state_d = S_GET_B;
                        default:  state_d = S_WAIT;
                    endcase
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    // Moore outputs from state and IR
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                asel = is_mov_reg;
                bsel = 1'b0;
                if (is_cmp) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            S_WR_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign shift = sh;
    assign aluop = op;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Scoreboard bench for rf_seq_ctrl: stimulus pushes expected strobe cycles, a negedge
// monitor pops and compares them; latency and reset behaviour are checked directly.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8, sximm5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [4:0]  strb;      // {write, loada, loadb, loadc, loads}
        logic        asel;
        logic        bsel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
    } rec_t;

    rec_t sb[$];

    rf_seq_ctrl #(.DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic rec_t mk(input logic [2:0] rn, input logic [2:0] wn,
                                input logic [4:0] strb, input logic a, input logic b,
                                input logic v, input logic [1:0] sh, input logic [1:0] op,
                                input logic [15:0] imm);
        rec_t r;
        r.readnum = rn; r.writenum = wn; r.strb = strb;
        r.asel = a; r.bsel = b; r.vsel = v;
        r.shift = sh; r.aluop = op; r.sximm8 = imm;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle with a strobe must match the next expected record
    always @(negedge clk) begin
        rec_t e;
        logic ok;
        logic [4:0] act_strb;
        act_strb = {write, loada, loadb, loadc, loads};
        if (rst_n && act_strb != 5'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got strb=%b readnum=%0d writenum=%0d with nothing expected",
                         act_strb, readnum, writenum);
            end else begin
                e  = sb.pop_front();
                ok = 1'b1;
                if (act_strb != e.strb) ok = 1'b0;
                if ((loada || loadb) && readnum != e.readnum) ok = 1'b0;
                if (write && (writenum != e.writenum || vsel != e.vsel)) ok = 1'b0;
                if ((loadc || loads) && (asel != e.asel || bsel != e.bsel)) ok = 1'b0;
                if (shift != e.shift || aluop != e.aluop || sximm8 != e.sximm8) ok = 1'b0;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL strobe_rec: got strb=%b rd=%0d wn=%0d a=%b b=%b v=%b sh=%0d op=%0d imm=%h expected strb=%b rd=%0d wn=%0d a=%b b=%b v=%b sh=%0d op=%0d imm=%h",
                             act_strb, readnum, writenum, asel, bsel, vsel, shift, aluop, sximm8,
                             e.strb, e.readnum, e.writenum, e.asel, e.bsel, e.vsel, e.shift, e.aluop, e.sximm8);
                end
            end
        end
    end

    // Called at posedge+1 with the FSM in WAIT; returns at edge0+1
    task automatic start(input logic [15:0] ins);
        s     = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        s = 1'b0;
    endtask

    // Counts edges (edge0 = 1) until w is seen high, bounded
    task automatic wait_w(input int n0, input int lat, input string name);
        int n;
        n = n0;
        while (!w && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, lat);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_w", int'(w), 1);
        check("rst_strobes", int'({write, loada, loadb, loadc, loads, asel, bsel, vsel}), 0);
        check("rst_readnum", int'(readnum), 0);
        check("rst_writenum", int'(writenum), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MOV R3,#-5
        sb.push_back(mk(3'd0, 3'd3, 5'b10000, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 16'hFFFB));
        start(16'hD3FB);
        wait_w(1, 3, "mov_imm_lat");

        // ADD R2,R1,R0 LSL#1
        sb.push_back(mk(3'd1, 3'd0, 5'b01000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        sb.push_back(mk(3'd0, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        sb.push_back(mk(3'd0, 3'd0, 5'b00010, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        sb.push_back(mk(3'd0, 3'd2, 5'b10000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        start(16'hA148);
        wait_w(1, 6, "add_lat");

        // CMP R5,R6
        sb.push_back(mk(3'd5, 3'd0, 5'b01000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 16'h0006));
        sb.push_back(mk(3'd6, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 16'h0006));
        sb.push_back(mk(3'd0, 3'd0, 5'b00001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 16'h0006));
        start(16'hAD06);
        wait_w(1, 5, "cmp_lat");

        // MOV R5,R2 LSR#1 (asel forced)
        sb.push_back(mk(3'd2, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 16'hFFB2));
        sb.push_back(mk(3'd0, 3'd0, 5'b00010, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 16'hFFB2));
        sb.push_back(mk(3'd0, 3'd5, 5'b10000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 16'hFFB2));
        start(16'hC0B2);
        wait_w(1, 5, "mov_reg_lat");

        // MVN R7,R2 with a stray start during GET_B
        sb.push_back(mk(3'd2, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 16'hFFE2));
        sb.push_back(mk(3'd0, 3'd0, 5'b00010, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 16'hFFE2));
        sb.push_back(mk(3'd0, 3'd7, 5'b10000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 16'hFFE2));
        start(16'hB8E2);
        @(posedge clk);
        #1;
        s     = 1'b1;
        instr = 16'h0000;
        @(posedge clk);
        #1;
        s = 1'b0;
        wait_w(3, 5, "mvn_lat");

        // Back-to-back MOV imm with s held high
        sb.push_back(mk(3'd0, 3'd3, 5'b10000, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 16'hFFFB));
        sb.push_back(mk(3'd0, 3'd7, 5'b10000, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 16'h0002));
        s     = 1'b1;
        instr = 16'hD3FB;
        @(posedge clk);
        #1;
        instr = 16'hD702;
        wait_w(1, 3, "b2b_lat1");
        @(posedge clk);
        #1;
        s = 1'b0;
        check("b2b_accept_w", int'(w), 0);
        wait_w(1, 3, "b2b_lat2");

        // Reset during EXEC of an ADD
        sb.push_back(mk(3'd1, 3'd0, 5'b01000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        sb.push_back(mk(3'd0, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0048));
        start(16'hA148);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_w", int'(w), 1);
        check("midrst_strobes", int'({write, loada, loadb, loadc, loads, asel, bsel, vsel}), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_w", int'(w), 1);

        // Illegal encoding
        start(16'hE000);
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
        repeat (8) @(posedge clk);
        #1;
        check("trap_hold_w", int'(w), 0);
        rst_n = 1'b0;
        #1;
        check("trap_reset_w", int'(w), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
`else
        wait_w(1, 2, "illegal_lat");
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
